// File: rtl/ag_tcu_order_merge_pkg.sv
// ag_tcu_order_merge_pkg
//   Shared constants and types for the AG tensor-core response-ordering stage.
//   PE indices, default order-FIFO depth, default result width, and the PE
//   select tag type carried through the order FIFO.
package ag_tcu_order_merge_pkg;

  localparam int AG_TCU_PE_FP       = 0;
  localparam int AG_TCU_PE_INT      = 1;
  localparam int AG_TCU_PE_COUNT    = 2;
  localparam int AG_TCU_ORDER_DEPTH = 8;
  localparam int AG_TCU_DATA_WIDTH  = 512;

  typedef logic [$clog2(AG_TCU_PE_COUNT)-1:0] ag_tcu_pe_sel_t;

  // Tag width for n PEs; never collapses to zero bits.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ag_tcu_order_merge_if.sv
// ag_tcu_order_merge_if
//   Handshake bundle around one issue block's FP/INT PE pair.
//   Request side : req_valid_in, req_pe_sel_in, req_ready_in (from PE switch),
//                  req_ready_out (to dispatch).
//   PE results   : rsp_valid_in[PE], rsp_data_in[PE*DW] (PE i at i*DW), rsp_ready_out[PE].
//   Merged output: rsp_valid_out, rsp_data_out, rsp_ready_in (from gather side).
//   Modport slave is the merge stage, master is the surrounding block.
interface ag_tcu_order_merge_if
  import ag_tcu_order_merge_pkg::*;
#(
  parameter int PE_COUNT   = AG_TCU_PE_COUNT,
  parameter int DATA_WIDTH = AG_TCU_DATA_WIDTH
);
  localparam int SEL_W = sel_width(PE_COUNT);

  logic                           req_valid_in;
  logic [SEL_W-1:0]               req_pe_sel_in;
  logic                           req_ready_in;
  logic                           req_ready_out;
  logic [PE_COUNT-1:0]            rsp_valid_in;
  logic [PE_COUNT*DATA_WIDTH-1:0] rsp_data_in;
  logic [PE_COUNT-1:0]            rsp_ready_out;
  logic                           rsp_valid_out;
  logic [DATA_WIDTH-1:0]          rsp_data_out;
  logic                           rsp_ready_in;

  modport slave (
    input  req_valid_in, req_pe_sel_in, req_ready_in,
    input  rsp_valid_in, rsp_data_in, rsp_ready_in,
    output req_ready_out, rsp_ready_out, rsp_valid_out, rsp_data_out
  );

  modport master (
    output req_valid_in, req_pe_sel_in, req_ready_in,
    output rsp_valid_in, rsp_data_in, rsp_ready_in,
    input  req_ready_out, rsp_ready_out, rsp_valid_out, rsp_data_out
  );

endinterface

// File: rtl/ag_tcu_order_merge_fifo.sv
// ag_tcu_order_fifo
//   Order FIFO of PE-select tags. One tag per request accepted into the PE
//   switch; the head tag names the PE whose result must commit next.
//   Ports: clk, reset (sync, active high), i_push/i_sel write side,
//          i_pop read side, o_head tag at rd_ptr, o_full, o_empty.
//   Caller guarantees no push while full and no pop while empty.
module ag_tcu_order_fifo
  import ag_tcu_order_merge_pkg::*;
#(
  parameter int DEPTH = AG_TCU_ORDER_DEPTH,
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_pop,
  output logic [SEL_W-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SEL_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Tag storage needs no reset: entries are only read below r_count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_sel;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/ag_tcu_order_merge.sv
// ag_tcu_order_merge
//   Response-ordering stage for one AG tensor-core issue block. Records the
//   PE select of every request entering the PE switch and merges the FP and
//   INT result streams back into strict issue order, so a fast INT op can
//   never overtake an older FP op of the same block.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset
//     bus         - ag_tcu_order_merge_if.slave (request observe, per-PE
//                   results, merged output)
//     perf_full_stalls, perf_hol_stalls - only with VX_AG_TCU_ORDER_PERF_EN
//   Optional feature macro: VX_AG_TCU_ORDER_PERF_EN (saturating stall counters).
//   The integrator must AND ~full (i.e. use req_ready_out) into the switch
//   valid so a request is never issued to a PE without an order slot.
module ag_tcu_order_merge
  import ag_tcu_order_merge_pkg::*;
#(
  parameter int PE_COUNT   = AG_TCU_PE_COUNT,
  parameter int DATA_WIDTH = AG_TCU_DATA_WIDTH,
  parameter int DEPTH      = AG_TCU_ORDER_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  ag_tcu_order_merge_if.slave   bus
`ifdef VX_AG_TCU_ORDER_PERF_EN
  ,
  output logic [31:0]           perf_full_stalls,
  output logic [31:0]           perf_hol_stalls
`endif
);
  localparam int SEL_W = sel_width(PE_COUNT);

  logic                  w_full, w_empty;
  logic                  w_req_ready, w_push, w_pop, w_slot_free;
  logic [SEL_W-1:0]      w_head;
  logic [PE_COUNT-1:0]   w_head_hit, w_rsp_ready, w_stall;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  // No bypass when full: a pop in the same cycle does not open a slot.
  assign w_req_ready = bus.req_ready_in & ~w_full;
  assign w_push      = bus.req_valid_in & w_req_ready;

  ag_tcu_order_fifo #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_sel   (bus.req_pe_sel_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_slot_free = ~r_rsp_valid | bus.rsp_ready_in;

  // Only the head PE may ever see ready; everyone else is held off.
  for (genvar i = 0; i < PE_COUNT; i++) begin : g_pe
    assign w_head_hit[i]  = ~w_empty & (w_head == SEL_W'(i));
    assign w_rsp_ready[i] = w_head_hit[i] & w_slot_free;
    assign w_stall[i]     = bus.rsp_valid_in[i] & ~w_head_hit[i];
  end

  assign w_pop = |(bus.rsp_valid_in & w_rsp_ready);

  always_comb begin
    w_head_data = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (w_head_hit[i]) w_head_data = bus.rsp_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Single-entry output register; refilling while draining keeps 1 result/cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_pop) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_head_data;
    end else if (bus.rsp_ready_in) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready_out = w_req_ready;
  assign bus.rsp_ready_out = w_rsp_ready;
  assign bus.rsp_valid_out = r_rsp_valid;
  assign bus.rsp_data_out  = r_rsp_data;

`ifdef VX_AG_TCU_ORDER_PERF_EN
  logic [31:0] r_perf_full, r_perf_hol;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_full <= '0;
      r_perf_hol  <= '0;
    end else begin
      if (bus.req_valid_in & bus.req_ready_in & w_full & ~&r_perf_full)
        r_perf_full <= r_perf_full + 32'd1;
      if (|w_stall & ~&r_perf_hol)
        r_perf_hol <= r_perf_hol + 32'd1;
    end
  end

  assign perf_full_stalls = r_perf_full;
  assign perf_hol_stalls  = r_perf_hol;
`endif

`ifndef SYNTHESIS
  // A PE result parked behind a head that never completes means the block hangs.
  for (genvar i = 0; i < PE_COUNT; i++) begin : g_chk
    logic [31:0] r_wait;
    always_ff @(posedge clk) begin
      if (reset)           r_wait <= '0;
      else if (w_stall[i]) r_wait <= r_wait + 32'd1;
      else                 r_wait <= '0;
    end
    a_deadlock: assert property (@(posedge clk) disable iff (reset)
      r_wait <= 32'(DEPTH * 64));
  end

  a_push_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_full));
`endif

endmodule

// File: tb/tb_ag_tcu_order_merge.sv
module tb_ag_tcu_order_merge;
  import ag_tcu_order_merge_pkg::*;

  localparam int NPE   = 2;
  localparam int DW    = 512;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ag_tcu_order_merge_if #(.PE_COUNT(NPE), .DATA_WIDTH(DW)) bus();

`ifdef VX_AG_TCU_ORDER_PERF_EN
  logic [31:0] perf_full_stalls, perf_hol_stalls;
`endif

  ag_tcu_order_merge #(.PE_COUNT(NPE), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef VX_AG_TCU_ORDER_PERF_EN
    ,
    .perf_full_stalls (perf_full_stalls),
    .perf_hol_stalls  (perf_hol_stalls)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding requests in issue order (PE select each), and what the
  // merged output must hold.
  int unsigned    order_q[$];
  logic           mdl_v;
  logic [DW-1:0]  mdl_d;
  bit             rand_mode = 0;
  int unsigned    out_seq = 0;
  logic [31:0]    m_full_st, m_hol_st;

  initial begin : cmp
    mdl_v = 1'b0; mdl_d = '0; m_full_st = '0; m_hol_st = '0;
    forever begin
      logic          rst_s, push, rdy_in, inc_f, inc_h, exp_r;
      int unsigned   psel;
      logic [NPE-1:0] hs;
      logic [DW-1:0] hd [NPE];
      @(negedge clk);
      rst_s = reset;
      if (!rst_s) begin
        chk("req_ready_out", bus.req_ready_out,
            bus.req_ready_in && (order_q.size() < DEPTH));
        for (int i = 0; i < NPE; i++) begin
          exp_r = (order_q.size() > 0) && (order_q[0] == i) && (!mdl_v || bus.rsp_ready_in);
          chk($sformatf("rsp_ready_out[%0d]", i), bus.rsp_ready_out[i], exp_r);
        end
        chk("rsp_valid_out", bus.rsp_valid_out, mdl_v);
        chk("rsp_data_out", bus.rsp_data_out, mdl_d);
`ifdef VX_AG_TCU_ORDER_PERF_EN
        chk("perf_full_stalls", perf_full_stalls, m_full_st);
        chk("perf_hol_stalls", perf_hol_stalls, m_hol_st);
`endif
      end
      push   = bus.req_valid_in && bus.req_ready_out;
      psel   = bus.req_pe_sel_in;
      hs     = bus.rsp_valid_in & bus.rsp_ready_out;
      rdy_in = bus.rsp_ready_in;
      for (int i = 0; i < NPE; i++) hd[i] = bus.rsp_data_in[i*DW +: DW];
      inc_f = bus.req_valid_in && bus.req_ready_in && (order_q.size() == DEPTH);
      inc_h = 1'b0;
      for (int i = 0; i < NPE; i++)
        if (bus.rsp_valid_in[i] && !(order_q.size() > 0 && order_q[0] == i)) inc_h = 1'b1;
      @(posedge clk);
      if (rst_s) begin
        order_q.delete();
        mdl_v = 1'b0; mdl_d = '0; m_full_st = '0; m_hol_st = '0;
      end else begin
        if (hs != '0) begin
          for (int i = 0; i < NPE; i++) if (hs[i]) begin
            mdl_v = 1'b1; mdl_d = hd[i];
            if (rand_mode) begin
              chk("issue_order_seq", hd[i][31:0], out_seq);
              out_seq++;
            end
          end
          if (order_q.size() > 0) void'(order_q.pop_front());
        end else if (rdy_in) begin
          mdl_v = 1'b0;
        end
        if (push) order_q.push_back(psel);
        if (inc_f && m_full_st != '1) m_full_st++;
        if (inc_h && m_hol_st != '1) m_hol_st++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_pe(input int i, input logic v, input logic [DW-1:0] d);
    bus.rsp_valid_in[i] = v;
    bus.rsp_data_in[i*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.req_valid_in = 1'b0;
    bus.req_pe_sel_in = '0;
    bus.rsp_valid_in = '0;
    bus.rsp_data_in = '0;
  endtask

  function automatic logic [DW-1:0] rnd_data(input int unsigned tag);
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
    d[31:0] = tag;
    return d;
  endfunction

  // Play the PEs: whichever PE owns the oldest request returns a result.
  task automatic drain(input int maxc);
    int c = 0;
    bus.req_valid_in = 1'b0;
    bus.rsp_ready_in = 1'b1;
    while ((order_q.size() > 0 || mdl_v) && c < maxc) begin
      for (int i = 0; i < NPE; i++)
        set_pe(i, (order_q.size() > 0) && (order_q[0] == i), rnd_data(32'hD000 + c));
      tick();
      c++;
    end
    bus.rsp_valid_in = '0;
    n_cmp++;
    if (c >= maxc) begin
      n_bad++;
      $display("FAIL drain_timeout: still %0d outstanding after %0d cycles", order_q.size(), c);
    end
  endtask

  typedef struct {
    int            pe;
    int            t;
    logic [DW-1:0] d;
  } pe_item_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [DW-1:0] pa, pb, pc, pe0;
    logic [DW-1:0] dd [4];
    pe_item_t      pq[$];
    int            seq, cyc, h_sel;
    logic          h_push;
    logic [NPE-1:0] h_hs;
    ag_tcu_pe_sel_t rs;

    pa = {64{8'hA5}};
    pb = {64{8'h3C}};
    pc = {64{8'h77}};
    pe0 = {64{8'hE1}};
    for (int k = 0; k < 4; k++) dd[k] = rnd_data(32'h100 + k);

    idle();
    bus.req_ready_in = 1'b1;
    bus.rsp_ready_in = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset values
    neg();
    chk("rst_valid_out", bus.rsp_valid_out, 1'b0);
    chk("rst_data_out", bus.rsp_data_out, '0);
    chk("rst_rsp_ready", bus.rsp_ready_out, 2'b00);
    chk("rst_req_ready", bus.req_ready_out, 1'b1);

    // Single FP op
    tick();
    bus.req_valid_in = 1'b1; bus.req_pe_sel_in = 1'b0;
    neg(); chk("t1_req_ready", bus.req_ready_out, 1'b1);
    tick();
    bus.req_valid_in = 1'b0; set_pe(0, 1'b1, pa);
    neg(); chk("t1_rsp_ready", bus.rsp_ready_out, 2'b01);
           chk("t1_no_out_yet", bus.rsp_valid_out, 1'b0);
    tick();
    set_pe(0, 1'b0, '0);
    neg(); chk("t1_valid", bus.rsp_valid_out, 1'b1);
           chk("t1_data", bus.rsp_data_out, pa);
           chk("t1_rsp_ready_after", bus.rsp_ready_out, 2'b00);
    tick();
    neg(); chk("t1_valid_clear", bus.rsp_valid_out, 1'b0);

    // Reorder: INT result early, must wait for FP
    tick();
    bus.req_valid_in = 1'b1; bus.req_pe_sel_in = 1'b0;
    tick();
    bus.req_pe_sel_in = 1'b1;
    tick();
    bus.req_valid_in = 1'b0; set_pe(1, 1'b1, pb);
    for (int k = 0; k < 3; k++) begin
      neg(); chk("t2_int_held", bus.rsp_ready_out[1], 1'b0);
             chk("t2_no_out", bus.rsp_valid_out, 1'b0);
      tick();
    end
    set_pe(0, 1'b1, pa);
    neg(); chk("t2_fp_ready", bus.rsp_ready_out, 2'b01);
    tick();
    set_pe(0, 1'b0, '0);
    neg(); chk("t2_first_fp", bus.rsp_data_out, pa);
           chk("t2_int_ready", bus.rsp_ready_out, 2'b10);
    tick();
    set_pe(1, 1'b0, '0);
    neg(); chk("t2_second_int", bus.rsp_data_out, pb);
           chk("t2_second_valid", bus.rsp_valid_out, 1'b1);
    tick();

    // Full
    bus.req_valid_in = 1'b1; bus.req_pe_sel_in = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      neg(); chk("t3_fill_ready", bus.req_ready_out, 1'b1);
      tick();
    end
    neg(); chk("t3_full", bus.req_ready_out, 1'b0);
    tick();
    set_pe(0, 1'b1, pc);
    neg(); chk("t3_full_with_pop", bus.req_ready_out, 1'b0);
           chk("t3_pop_ready", bus.rsp_ready_out, 2'b01);
    tick();
    set_pe(0, 1'b0, '0);
    neg(); chk("t3_after_pop", bus.req_ready_out, 1'b1);
    tick();
    drain(100);

    // Backpressure then full-rate release
    bus.rsp_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.req_valid_in = 1'b1; bus.req_pe_sel_in = ag_tcu_pe_sel_t'(k % 2);
      tick();
    end
    bus.req_valid_in = 1'b0;
    set_pe(0, 1'b1, dd[0]);
    tick();
    set_pe(0, 1'b0, '0); set_pe(1, 1'b1, dd[1]);
    for (int k = 0; k < 3; k++) begin
      neg(); chk("t4_stall_ready", bus.rsp_ready_out, 2'b00);
             chk("t4_stall_data", bus.rsp_data_out, dd[0]);
      tick();
    end
    bus.rsp_ready_in = 1'b1;
    neg(); chk("t4_release_ready", bus.rsp_ready_out, 2'b10);
    tick();
    set_pe(1, 1'b0, '0); set_pe(0, 1'b1, dd[2]);
    neg(); chk("t4_beat1", bus.rsp_data_out, dd[1]);
    tick();
    set_pe(0, 1'b0, '0); set_pe(1, 1'b1, dd[3]);
    neg(); chk("t4_beat2", bus.rsp_data_out, dd[2]);
    tick();
    set_pe(1, 1'b0, '0);
    neg(); chk("t4_beat3", bus.rsp_data_out, dd[3]);
           chk("t4_beat3_valid", bus.rsp_valid_out, 1'b1);
    tick();
    drain(20);

    // Randomized traffic with emulated variable-latency PEs
    seq = 0; cyc = 0; out_seq = 0; rand_mode = 1;
    for (int n = 0; n < 2600; n++) begin
      neg();
      h_push = bus.req_valid_in && bus.req_ready_out;
      h_sel  = int'(bus.req_pe_sel_in);
      h_hs   = bus.rsp_valid_in & bus.rsp_ready_out;
      tick();
      cyc++;
      if (h_push) begin
        pe_item_t it;
        it.pe = h_sel;
        it.t  = cyc + ((h_sel == AG_TCU_PE_FP) ? int'($urandom_range(1, 6)) : int'($urandom_range(0, 2)));
        it.d  = rnd_data(seq);
        pq.push_back(it);
        seq++;
      end
      for (int i = 0; i < NPE; i++) if (h_hs[i]) begin
        for (int k = 0; k < pq.size(); k++) if (pq[k].pe == i) begin
          pq.delete(k);
          break;
        end
      end
      if (n < 2000) begin
        rs = ag_tcu_pe_sel_t'($urandom_range(AG_TCU_PE_FP, AG_TCU_PE_INT));
        bus.req_valid_in  = ($urandom_range(0, 9) < 6);
        bus.req_pe_sel_in = rs;
        bus.req_ready_in  = ($urandom_range(0, 9) < 8);
        bus.rsp_ready_in  = ($urandom_range(0, 9) < 7);
      end else begin
        bus.req_valid_in = 1'b0;
        bus.req_ready_in = 1'b1;
        bus.rsp_ready_in = 1'b1;
      end
      for (int i = 0; i < NPE; i++) begin
        set_pe(i, 1'b0, '0);
        for (int k = 0; k < pq.size(); k++) if (pq[k].pe == i) begin
          set_pe(i, pq[k].t <= cyc, pq[k].d);
          break;
        end
      end
      if (n >= 2000 && pq.size() == 0 && order_q.size() == 0 && !mdl_v) break;
    end
    idle();
    bus.req_ready_in = 1'b1;
    rand_mode = 0;
    chk("rand_drained", (pq.size() == 0) && (order_q.size() == 0), 1'b1);
    chk("rand_all_returned", out_seq, seq);

    // Reset in the middle of operation
    tick();
    bus.rsp_ready_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid_in = 1'b1; bus.req_pe_sel_in = ag_tcu_pe_sel_t'(k % 2);
      tick();
    end
    bus.req_valid_in = 1'b0;
    set_pe(0, 1'b1, pe0);
    tick();
    set_pe(0, 1'b0, '0);
    neg(); chk("t6_pre_valid", bus.rsp_valid_out, 1'b1);
           chk("t6_pre_data", bus.rsp_data_out, pe0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    neg(); chk("t6_valid", bus.rsp_valid_out, 1'b0);
           chk("t6_data", bus.rsp_data_out, '0);
           chk("t6_rsp_ready", bus.rsp_ready_out, 2'b00);
           chk("t6_req_ready", bus.req_ready_out, 1'b1);
`ifdef VX_AG_TCU_ORDER_PERF_EN
           chk("t6_perf_full", perf_full_stalls, 32'd0);
           chk("t6_perf_hol", perf_hol_stalls, 32'd0);
`endif
    tick();
    bus.req_valid_in = 1'b1; bus.req_pe_sel_in = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      neg(); chk("t6_refill_ready", bus.req_ready_out, 1'b1);
      tick();
    end
    neg(); chk("t6_full_again", bus.req_ready_out, 1'b0);
    tick();
    drain(100);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ag_tcu_order_merge.md
Name: ag_tcu_order_merge

Overview:
- Per-block response-ordering stage for the AG tensor-core unit.
- Sits around the FP/INT PE pair of one issue block:
  - observes the request handshake into the PE switch and records each request's PE select in an order FIFO;
  - merges the two PE result streams back into one stream in strict issue order.
- Needed because the FP and INT PEs have different latencies; without it a later INT op could commit before an earlier FP op of the same block.

Parameters:
- PE_COUNT, 2, number of PEs merged; index 0 = FP, 1 = INT.
- DATA_WIDTH, 512, width of one flattened result payload in bits.
- DEPTH, 8, maximum outstanding requests tracked; power of two, >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  1  request valid from dispatch side.
- req_pe_sel_in  in  $clog2(PE_COUNT)  PE chosen for the request (fmt_s[3] for 2 PEs).
- req_ready_in  in  1  ready from the downstream PE switch.
- req_ready_out  out  1  ready presented to dispatch = req_ready_in & ~full.
- rsp_valid_in  in  PE_COUNT  per-PE result valid.
- rsp_data_in  in  PE_COUNT*DATA_WIDTH  per-PE result payload; PE i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_ready_out  out  PE_COUNT  per-PE result ready.
- rsp_valid_out  out  1  merged result valid.
- rsp_data_out  out  DATA_WIDTH  merged result payload.
- rsp_ready_in  in  1  ready from the gather side.

Behaviour:
- Push:
  - push = req_valid_in & req_ready_out; req_pe_sel_in is written at wr_ptr and wr_ptr increments.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH+1) bits. full = (count == DEPTH); empty = (count == 0).
- Push gating:
  - Full gates the push with no same-cycle bypass: when full, req_ready_out = 0 even if a pop occurs that cycle.
  - When full, the request handshake to the PE switch must also be blocked; the integrator ANDs ~full into the switch valid.
- Head selection: head = fifo[rd_ptr]. rsp_ready_out[i] = ~empty & (head == i) & out_slot_free; all other PEs see ready = 0.
- Pop: pop = ~empty & rsp_valid_in[head] & rsp_ready_out[head]. Pop increments rd_ptr.
- Output register:
  - 1-entry, full throughput; out_slot_free = ~rsp_valid_out | rsp_ready_in.
  - On pop: rsp_valid_out <= 1 and rsp_data_out <= the head PE slice.
  - Else if rsp_ready_in: rsp_valid_out <= 0.
  - rsp_data_out holds its value when there is no pop.
- Latency: 1 cycle from accepted PE result to rsp_valid_out. Back-to-back pops sustain 1 result per cycle.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Push to an empty FIFO: the entry becomes head on the next cycle. A same-cycle result cannot be accepted.
- Reset (synchronous, also mid-operation):
  - wr_ptr, rd_ptr, count, rsp_valid_out, rsp_data_out all go to 0.
  - In-flight order entries are discarded; the PEs are reset by the same signal.
- Reset values of outputs: rsp_valid_out = 0, rsp_data_out = 0, rsp_ready_out = 0 (empty), req_ready_out = req_ready_in.
- Error checks (simulation assertions):
  - rsp_valid_in[i] while empty or head != i for more than DEPTH*64 cycles is a deadlock.
  - A push while full is illegal.
- No state machine beyond the FIFO: state is {count, wr_ptr, rd_ptr, out register}.

Optional Feature:
- Macro: VX_AG_TCU_ORDER_PERF_EN.
- When defined, two extra output ports exist:
  - perf_full_stalls (32 bits): increments each cycle req_valid_in & req_ready_in & full.
  - perf_hol_stalls (32 bits): increments each cycle some non-head PE has rsp_valid_in = 1.
- Both counters reset to 0 and saturate at all-ones.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- VX_ag_tcu_pkg gains:
  - AG_TCU_PE_FP = 0 and AG_TCU_PE_INT = 1;
  - AG_TCU_ORDER_DEPTH = 8;
  - typedef ag_tcu_pe_sel_t, a $clog2(PE_COUNT)-bit logic.
- One natural sub-module: ag_tcu_order_fifo, the pointer/count FIFO of pe_sel tags with full/empty.
- The merge mux and output register stay in the top module.

Test Plan:
- Single op: push sel=0, FP result 0xA5.. at cycle 5 -> rsp_valid_out=1 at cycle 6 with data 0xA5.., rsp_ready_out[1]=0 throughout.
- Reorder: push sel=0 then sel=1; INT result arrives 3 cycles before FP -> INT held (rsp_ready_out[1]=0) until FP is output; output order FP then INT.
- Full: 8 pushes with no results -> req_ready_out=0 on the 9th. A same-cycle pop when full still gives req_ready_out=0. The next cycle, req_ready_out=1.
- Backpressure: rsp_ready_in=0 with valid output -> rsp_ready_out all 0, data stable. Release -> 1 result per cycle for 4 queued results with alternating sel 0,1,0,1.
- Wrap: 20 pushes/pops with count oscillating 0..3 -> pointers wrap past 7, order preserved.
- Reset mid-operation: 5 outstanding entries, assert reset 1 cycle -> count=0, rsp_valid_out=0 next cycle. With PERF_EN, both counters read 0.
